// File: rtl/llander_pkg.sv
// Shared lunar-lander constants and the thrust lever type.
package llander_pkg;

  localparam int THRUST_MAX    = 254;
  localparam int TICK_DIV_DFLT = 196_850;

  typedef logic [7:0] thrust_t;

endpackage

// File: rtl/thrust_tick_gen.sv
// Ramp step divider: tick is high for the one cycle where the count sits at TICK_DIV-1.
// Latency: first tick in the TICK_DIV-th cycle after reset release; no backpressure.
module thrust_tick_gen
  import llander_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DFLT
) (
  input  logic CLK_50M,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tcnt;
  logic [CW-1:0] tcnt_nxt;

  always_comb begin
    tcnt_nxt = (tcnt == LAST) ? '0 : tcnt + CW'(1);
  end

  // tick is registered but aligned with the count value it marks
  always_ff @(posedge CLK_50M or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
      tick <= 1'b0;
    end else begin
      tcnt <= tcnt_nxt;
      tick <= (tcnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/thrust_ctrl.sv
// Thrust lever conditioning: D-pad ramp or slew-limited analog stick, bumpless source switch.
// Latency: accumulators step the cycle after tick, thrust follows one cycle later; no backpressure.
module thrust_ctrl
  import llander_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DFLT,
  parameter int THRUST_MAX = llander_pkg::THRUST_MAX,
  parameter int DEADZONE   = 8,
  parameter int SLEW_STEP  = 16
) (
  input  logic              CLK_50M,
  input  logic              reset,
  input  logic              mode_dpad,
  input  logic signed [7:0] analog_y,
  input  logic              dpad_up,
  input  logic              dpad_down,
  output thrust_t           thrust,
  output logic              tick,
  output logic              at_max,
  output logic              at_zero
);

  localparam thrust_t           TMAX  = 8'(THRUST_MAX);
  localparam thrust_t           SLEW8 = 8'(SLEW_STEP);
  localparam logic signed [8:0] TMAX9 = 9'(THRUST_MAX);
  localparam logic signed [8:0] DZ9   = 9'(DEADZONE);
  localparam logic signed [8:0] SLEW9 = 9'(SLEW_STEP);

  logic              mode_q;
  logic              mode_edge;
  thrust_t           dacc, aacc;
  thrust_t           dacc_step, aacc_step;
  thrust_t           tgt8, thrust_nxt;
  logic signed [8:0] tgt, diff;

  thrust_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK_50M (CLK_50M),
    .reset   (reset),
    .tick    (tick)
  );

  always_comb begin
    // full up (-128) maps to 255 before clamping
    tgt = 9'sd127 - $signed({analog_y[7], analog_y});
    if (tgt < DZ9)        tgt8 = '0;
    else if (tgt > TMAX9) tgt8 = TMAX;
    else                  tgt8 = tgt[7:0];

    diff = $signed({1'b0, tgt8}) - $signed({1'b0, aacc});
    if (diff > SLEW9)       aacc_step = aacc + SLEW8;
    else if (diff < -SLEW9) aacc_step = aacc - SLEW8;
    else                    aacc_step = tgt8;

    dacc_step = dacc;
    if (dpad_up && !dpad_down && (dacc < TMAX))
      dacc_step = dacc + 8'd1;
    else if (dpad_down && !dpad_up && (dacc != '0))
      dacc_step = dacc - 8'd1;

    thrust_nxt = mode_q ? dacc : aacc;
    if (thrust_nxt > TMAX) thrust_nxt = TMAX;

    mode_edge = (mode_dpad != mode_q);
  end

  // a source switch seeds the new accumulator from the live output, winning over a tick step
  always_ff @(posedge CLK_50M or posedge reset) begin
    if (reset) begin
      mode_q  <= 1'b0;
      dacc    <= '0;
      aacc    <= '0;
      thrust  <= '0;
      at_max  <= 1'b0;
      at_zero <= 1'b1;
    end else begin
      mode_q <= mode_dpad;

      if (mode_edge && mode_dpad) dacc <= thrust;
      else if (tick)              dacc <= dacc_step;

      if (mode_edge && !mode_dpad) aacc <= thrust;
      else if (tick)               aacc <= aacc_step;

      thrust  <= thrust_nxt;
      at_max  <= (thrust_nxt == TMAX);
      at_zero <= (thrust_nxt == '0);
    end
  end

endmodule
